// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: drives the dmem req/ack bus, stalls the pipeline
// while an access is outstanding and formats load data for MEM_WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] ALURes_MEM,
    input  logic [31:0] MemWrData_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MemRdData_MEM,
    output logic        stall,
    output logic        access_err,
    output logic        bus_err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dmem_req;
    logic          r_dmem_we;
    logic [31:0]   r_dmem_addr;
    logic [31:0]   r_dmem_wdata;
    logic [3:0]    r_dmem_be;
    logic [31:0]   r_rd_buf;
    logic          r_load;
    logic [2:0]    r_f3;
    logic [1:0]    r_alo;
    logic          r_abort;

    logic          w_acc;
    logic          w_mis;
    logic          w_illegal;
    logic          w_bad;
    logic          w_start;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shift;
    logic [15:0]   w_half;
    logic [31:0]   w_fmt;

    assign w_acc     = valid_MEM & (MemRead_MEM | MemWrite_MEM);
    assign w_illegal = (funct3_MEM == 3'b011) | (funct3_MEM == 3'b110) | (funct3_MEM == 3'b111);
    assign w_mis     = ((funct3_MEM[1:0] == 2'b01) & ALURes_MEM[0])
                     | ((funct3_MEM[1:0] == 2'b10) & (ALURes_MEM[1:0] != 2'b00));
    assign w_bad     = w_illegal | w_mis;
    assign w_start   = w_acc & ~w_bad;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MemWrData_MEM;
        case (funct3_MEM[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALURes_MEM[1:0];
                w_wdata = {4{MemWrData_MEM[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ALURes_MEM[1:0];
                w_wdata = {2{MemWrData_MEM[15:0]}};
            end
            default: ;
        endcase
        if (MemRead_MEM)
            w_be = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= '0;
            r_rd_buf     <= '0;
            r_load       <= 1'b0;
            r_f3         <= '0;
            r_alo        <= '0;
            r_abort      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_start) begin
                        r_state      <= S_REQ;
                        r_cnt        <= '0;
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= MemWrite_MEM;
                        r_dmem_addr  <= {ALURes_MEM[31:2], 2'b00};
                        r_dmem_wdata <= w_wdata;
                        r_dmem_be    <= w_be;
                        r_load       <= MemRead_MEM;
                        r_f3         <= funct3_MEM;
                        r_alo        <= ALURes_MEM[1:0];
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_rd_buf   <= dmem_rdata;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_dmem_be  <= '0;
                        r_state    <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rd_buf   <= '0;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_dmem_be  <= '0;
                        r_abort    <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lane selection uses the address latched at REQ entry, not the live ALU result.
    assign w_shift = r_rd_buf >> {r_alo, 3'b000};
    assign w_half  = r_alo[1] ? r_rd_buf[31:16] : r_rd_buf[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_fmt = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b010:  w_fmt = r_rd_buf;
            3'b100:  w_fmt = {24'd0, w_shift[7:0]};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = '0;
        endcase
    end

    assign MemRdData_MEM = ((r_state == S_DONE) && r_load) ? w_fmt : '0;
    assign stall         = ((r_state == S_IDLE) & w_start) | (r_state == S_REQ);
    assign access_err    = (r_state == S_IDLE) & w_acc & w_bad;
    assign bus_err       = (r_state == S_DONE) & r_abort;
    assign dmem_req      = r_dmem_req;
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign dmem_be       = r_dmem_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// checked cycle by cycle against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_MEM, MemRead_MEM, MemWrite_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] ALURes_MEM, MemWrData_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] MemRdData_MEM;
    logic        stall, access_err, bus_err;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_MEM(valid_MEM), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .funct3_MEM(funct3_MEM), .ALURes_MEM(ALURes_MEM),
        .MemWrData_MEM(MemWrData_MEM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .MemRdData_MEM(MemRdData_MEM),
        .stall(stall), .access_err(access_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes and load formatting.
    function automatic int unsigned m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_bad(input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        return !legal || ((a % m_size(f3)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int unsigned s;
        s = m_size(f3);
        if (ld || s == 4) return 4'hF;
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1: return {24'd0, wd[7:0]} * 32'h01010101;
            2: return {16'd0, wd[15:0]} * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic txn(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int waits, input bit to);
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        bit          acked;
        e_wdata = m_wdata(f3, wd);
        e_be    = m_be(rd, f3, a);
        acked   = 1'b0;
        @(negedge clk);
        valid_MEM = v; MemRead_MEM = rd; MemWrite_MEM = wr; funct3_MEM = f3;
        ALURes_MEM = a; MemWrData_MEM = wd; dmem_ack = 1'b0;
        #1;
        if (!(v && (rd || wr))) begin
            chk("nop_stall", 32'(stall), 0);
            chk("nop_req", 32'(dmem_req), 0);
            chk("nop_aerr", 32'(access_err), 0);
            chk("nop_rdata", MemRdData_MEM, 0);
            return;
        end
        if (m_bad(f3, a)) begin
            chk("bad_aerr", 32'(access_err), 1);
            chk("bad_stall", 32'(stall), 0);
            chk("bad_req", 32'(dmem_req), 0);
            chk("bad_rdata", MemRdData_MEM, 0);
            return;
        end
        chk("start_stall", 32'(stall), 1);
        chk("start_req", 32'(dmem_req), 0);
        chk("start_aerr", 32'(access_err), 0);
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            ALURes_MEM = $urandom; MemWrData_MEM = $urandom; funct3_MEM = 3'($urandom);
            dmem_ack   = !to && (k == waits);
            dmem_rdata = dmem_ack ? rdat : $urandom;
            #1;
            chk("req_req", 32'(dmem_req), 1);
            chk("req_we", 32'(dmem_we), 32'(wr));
            chk("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("req_wdata", dmem_wdata, e_wdata);
            chk("req_be", 32'(dmem_be), 32'(e_be));
            chk("req_stall", 32'(stall), 1);
            chk("req_errs", {30'd0, access_err, bus_err}, 0);
            if (dmem_ack) begin
                acked = 1'b1;
                break;
            end
        end
        if (!to)
            chk("ack_seen", 32'(acked), 1);
        @(negedge clk);
        valid_MEM = 1'b0; dmem_ack = 1'b0; dmem_rdata = $urandom;
        #1;
        chk("done_stall", 32'(stall), 0);
        chk("done_req", 32'(dmem_req), 0);
        chk("done_buserr", 32'(bus_err), 32'(to));
        chk("done_rdata", MemRdData_MEM, (rd && !to) ? m_load(f3, a, rdat) : 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        rd;
        rst_n = 1'b0; valid_MEM = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        funct3_MEM = '0; ALURes_MEM = '0; MemWrData_MEM = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we_be", {27'd0, dmem_we, dmem_be}, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_errs", {30'd0, access_err, bus_err}, 0);
        chk("rst_rdata", MemRdData_MEM, 0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        txn(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 0);
        txn(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
        txn(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 2, 0);
        txn(1, 0, 1, 3'b000, 32'h201, 32'hAB, 32'h12345678, 3, 0);
        txn(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
        txn(1, 0, 1, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0);
        txn(1, 1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0, 1);
        txn(1, 1, 0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, int'(TO) - 1, 0);

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        valid_MEM = 1'b1; MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0;
        funct3_MEM = 3'b010; ALURes_MEM = 32'h300;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_req", 32'(dmem_req), 1);
        rst_n = 1'b0; valid_MEM = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid_req", 32'(dmem_req), 0);
        chk("rstmid_stall", 32'(stall), 0);
        chk("rstmid_be", 32'(dmem_be), 0);
        rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        #1;
        chk("late_ack_req", 32'(dmem_req), 0);
        chk("late_ack_stall", 32'(stall), 0);
        chk("late_ack_rdata", MemRdData_MEM, 0);
        chk("late_ack_err", {30'd0, access_err, bus_err}, 0);
        dmem_ack = 1'b0;
        txn(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 1, 0);

        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            rd = 1'($urandom);
            if ($urandom_range(0, 1) == 0)
                a = a & ~(32'(m_size(f3)) - 1);
            txn($urandom_range(0, 7) != 0, rd, ($urandom_range(0, 9) == 0) ? 1'b0 : !rd,
                f3, a, $urandom, $urandom, $urandom_range(0, 4), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
